// File: rtl/cnnpr_mem_pkg.sv
// Shared defaults and state encoding for the cache read path.
package cnnpr_mem_pkg;

  localparam int CACHE_WIDTH_DEF = 162;
  localparam int SEG_WIDTH_DEF   = 18;
  localparam int READ_LAT_DEF    = 1;
  localparam int CNT_WIDTH_DEF   = 16;
  localparam int NUM_SEG_DEF     = CACHE_WIDTH_DEF / SEG_WIDTH_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rd_state_e;

  // Index width that stays legal when the range has a single value.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_word_buf.sv
// Two-entry word FIFO between the cache read port and the segment mux.
module cache_word_buf #(
  parameter int WIDTH = 162
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [1:0]       o_used,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_used;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_used   <= 2'd0;
    end else if (i_en) begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      // Simultaneous push and pop leave the fill level unchanged.
      case ({i_push, i_pop})
        2'b10:   r_used <= r_used + 2'd1;
        2'b01:   r_used <= r_used - 2'd1;
        default: r_used <= r_used;
      endcase
    end
  end

  assign o_used = r_used;
  assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/cache_reader.sv
// Pops cache words from mem_controller and streams them out LSB-first as
// SEG_WIDTH segments on a valid/ready interface, one job per start command.
//
// state   | meaning
// IDLE    | waiting for start; word_count latched on start
// RUN     | issuing pops and draining segments; busy high
// DONE    | one-cycle done pulse, then back to IDLE
module cache_reader
  import cnnpr_mem_pkg::*;
#(
  parameter  int CACHE_WIDTH = CACHE_WIDTH_DEF,
  parameter  int SEG_WIDTH   = SEG_WIDTH_DEF,
  parameter  int READ_LAT    = READ_LAT_DEF,
  parameter  int CNT_WIDTH   = CNT_WIDTH_DEF,
  localparam int NUM_SEG     = CACHE_WIDTH / SEG_WIDTH,
  localparam int IDX_W       = idx_width(NUM_SEG)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   read_req02,
  input  logic [CACHE_WIDTH-1:0] cache02_out,
  input  logic                   empty02,
  output logic                   seg_valid,
  input  logic                   seg_ready,
  output logic [SEG_WIDTH-1:0]   seg_data,
  output logic [IDX_W-1:0]       seg_idx,
  output logic                   seg_last
);

  localparam int OUT_W = idx_width(READ_LAT + 1);

  if (CACHE_WIDTH % SEG_WIDTH != 0) begin : g_bad_width
    $error("cache_reader: CACHE_WIDTH must be a multiple of SEG_WIDTH");
  end
  if (READ_LAT < 1) begin : g_bad_lat
    $error("cache_reader: READ_LAT must be at least 1");
  end

  rd_state_e              r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_word_count;
  logic [CNT_WIDTH-1:0]   r_req_cnt;
  logic [CNT_WIDTH-1:0]   r_out_cnt;
  logic [IDX_W-1:0]       r_seg_idx;
  logic [READ_LAT-1:0]    r_vld_pipe;
  logic [OUT_W-1:0]       r_outst;
  logic [1:0]             w_used;
  logic [CACHE_WIDTH-1:0] w_head;
  logic                   w_capture, w_credit_ok, w_hs, w_seg_end, w_buf_pop, w_last_word;

  assign w_capture   = r_vld_pipe[READ_LAT-1];
  // Words buffered plus words in flight never exceed the two buffer slots.
  assign w_credit_ok = (int'(w_used) + int'(r_outst)) < 2;
  assign read_req02  = clk_en & (r_state == ST_RUN) & ~empty02 &
                       (r_req_cnt < r_word_count) & w_credit_ok;

  assign seg_valid   = (w_used != 2'd0);
  assign w_hs        = clk_en & seg_valid & seg_ready;
  assign w_seg_end   = (r_seg_idx == IDX_W'(NUM_SEG - 1));
  assign w_buf_pop   = w_hs & w_seg_end;
  assign w_last_word = ((r_out_cnt + CNT_WIDTH'(1)) == r_word_count);
  assign seg_last    = seg_valid & w_seg_end & w_last_word;
  assign seg_idx     = r_seg_idx;
  assign seg_data    = w_head[int'(r_seg_idx) * SEG_WIDTH +: SEG_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n)      r_state <= ST_IDLE;
    else if (clk_en) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = (word_count != '0) ? ST_RUN : ST_DONE;
      ST_RUN: begin
        busy = 1'b1;
        if (w_buf_pop && w_last_word) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word_count <= '0;
      r_req_cnt    <= '0;
      r_out_cnt    <= '0;
      r_seg_idx    <= '0;
      r_vld_pipe   <= '0;
      r_outst      <= '0;
    end else if (clk_en) begin
      r_vld_pipe[0] <= read_req02;
      for (int i = 1; i < READ_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      case ({read_req02, w_capture})
        2'b10:   r_outst <= r_outst + OUT_W'(1);
        2'b01:   r_outst <= r_outst - OUT_W'(1);
        default: r_outst <= r_outst;
      endcase
      if (r_state == ST_IDLE && start) begin
        r_word_count <= word_count;
        r_req_cnt    <= '0;
        r_out_cnt    <= '0;
        r_seg_idx    <= '0;
      end else begin
        if (read_req02) r_req_cnt <= r_req_cnt + CNT_WIDTH'(1);
        if (w_hs)       r_seg_idx <= w_seg_end ? '0 : r_seg_idx + IDX_W'(1);
        if (w_buf_pop)  r_out_cnt <= r_out_cnt + CNT_WIDTH'(1);
      end
    end
  end

  cache_word_buf #(.WIDTH(CACHE_WIDTH)) u_word_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (clk_en),
    .i_push (w_capture),
    .i_data (cache02_out),
    .i_pop  (w_buf_pop),
    .o_used (w_used),
    .o_head (w_head)
  );

endmodule

// File: tb/tb_cache_reader.sv
// Randomized bench for cache_reader: memory model, segment scoreboard, job-level checks.
module tb_cache_reader;

  localparam int CW = 162;
  localparam int SW = 18;
  localparam int NS = 9;

  logic          clk = 1'b0;
  logic          rst_n, clk_en, start;
  logic [15:0]   word_count;
  logic          busy, done, read_req02;
  logic [CW-1:0] cache02_out;
  logic          empty02, seg_valid, seg_ready, seg_last;
  logic [SW-1:0] seg_data;
  logic [3:0]    seg_idx;

  cache_reader dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .word_count(word_count),
    .busy(busy), .done(done), .read_req02(read_req02), .cache02_out(cache02_out),
    .empty02(empty02), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_data(seg_data), .seg_idx(seg_idx), .seg_last(seg_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [CW-1:0] word_q[$];
  logic [SW-1:0] exp_q[$];
  int  cyc = 0, issued, drained, hs_cnt, done_cnt, done_cyc, first_hs, last_hs, job_wc, start_cyc;
  int  rdy_mode = 0, emp_mode = 0, emp_hold = 0;
  bit  prev_done = 0, busy_seen;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // mem_controller model: a pop seen at an enabled edge returns its word one cycle later
  initial begin : mem_model
    logic r, en, rs;
    logic [CW-1:0] w;
    forever begin
      @(negedge clk);
      r = read_req02; en = clk_en; rs = rst_n;
      @(posedge clk); #1;
      if (en && rs) begin
        if (r) begin
          if (word_q.size() > 0) w = word_q.pop_front();
          else for (int j = 0; j < NS; j++) w[j*SW +: SW] = SW'($urandom);
          for (int j = 0; j < NS; j++) exp_q.push_back(w[j*SW +: SW]);
          cache02_out = w;
        end else begin
          for (int j = 0; j < NS; j++) cache02_out[j*SW +: SW] = SW'($urandom);
        end
      end
    end
  end

  initial begin : drivers
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       seg_ready = 1'b1;
        1:       seg_ready = ~seg_ready;
        default: seg_ready = 1'($urandom_range(0, 1));
      endcase
      case (emp_mode)
        0:       empty02 = 1'b0;
        1:       empty02 = ($urandom_range(0, 3) == 0);
        default: if (issued > 0 && emp_hold < 5) begin
                   empty02 = 1'b1;
                   emp_hold++;
                 end else empty02 = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    logic [SW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!clk_en) chk("req_gated", 64'(read_req02), 64'd0);
        if (read_req02) begin
          issued++;
          chk("req_empty", 64'(empty02), 64'd0);
          chk("credit", 64'((issued - drained) <= 2), 64'd1);
        end
        if (busy) busy_seen = 1;
        if (clk_en) begin
          if (seg_valid && seg_ready) begin
            chk("sb_avail", 64'(exp_q.size() != 0), 64'd1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            chk("seg_data", 64'(seg_data), 64'(e));
            chk("seg_idx", 64'(seg_idx), 64'(hs_cnt % NS));
            chk("seg_last", 64'(seg_last), 64'(hs_cnt == job_wc * NS - 1));
            if (hs_cnt % NS == NS - 1) drained++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            hs_cnt++;
          end
          if (done) begin
            chk("done_width", 64'(prev_done), 64'd0);
            chk("done_busy", 64'(busy), 64'd0);
            done_cnt++;
            done_cyc = cyc;
          end
          prev_done = done;
        end
      end
    end
  end

  task automatic clear_job(input int wc);
    word_q.delete(); exp_q.delete();
    issued = 0; drained = 0; hs_cnt = 0; done_cnt = 0;
    first_hs = -1; last_hs = -1; busy_seen = 0; emp_hold = 0; job_wc = wc;
  endtask

  task automatic run_job(input int wc, input int rdy_m, input int emp_m,
                         input int freeze_at, input int restart_at, input bit pattern);
    logic [CW-1:0] w;
    logic [SW-1:0] s_data;
    logic [3:0]    s_idx;
    logic          s_valid, s_busy;
    int            k;
    clear_job(wc);
    for (int n = 0; n < wc; n++) begin
      for (int j = 0; j < NS; j++) w[j*SW +: SW] = pattern ? SW'(n * 16 + j) : SW'($urandom);
      word_q.push_back(w);
    end
    rdy_mode = rdy_m; emp_mode = emp_m;
    @(posedge clk); #1;
    start = 1'b1; word_count = 16'(wc); start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; word_count = 16'($urandom);
    chk("busy_on", 64'(busy), 64'(wc != 0));
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      @(posedge clk); #1;
      k++;
      start = (k == restart_at);
      if (start) word_count = 16'd7;
      if (k == freeze_at) begin
        clk_en = 1'b0;
        s_data = seg_data; s_idx = seg_idx; s_valid = seg_valid; s_busy = busy;
        repeat (4) begin
          @(negedge clk);
          chk("frz_data", 64'(seg_data), 64'(s_data));
          chk("frz_idx", 64'(seg_idx), 64'(s_idx));
          chk("frz_valid", 64'(seg_valid), 64'(s_valid));
          chk("frz_busy", 64'(busy), 64'(s_busy));
          @(posedge clk); #1;
          k++;
        end
        clk_en = 1'b1;
      end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("seg_total", 64'(hs_cnt), 64'(wc * NS));
    chk("pop_total", 64'(issued), 64'(wc));
    chk("sb_left", 64'(exp_q.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    if (wc > 0) chk("done_lat", 64'(done_cyc - last_hs), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_req"}, 64'(read_req02), 64'd0);
    chk({tag, "_valid"}, 64'(seg_valid), 64'd0);
    chk({tag, "_last"}, 64'(seg_last), 64'd0);
    chk({tag, "_idx"}, 64'(seg_idx), 64'd0);
    chk({tag, "_data"}, 64'(seg_data), 64'd0);
  endtask

  initial begin : stimulus
    int k, ghost, wc;
    rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; word_count = '0;
    cache02_out = '0; empty02 = 1'b0; seg_ready = 1'b0;
    clear_job(0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // three patterned words, full throughput
    run_job(3, 0, 0, 0, 0, 1'b1);
    chk("b2b_span", 64'(last_hs - first_hs), 64'd26);
    // empty02 held high for 5 cycles after the first pop
    run_job(3, 0, 2, 0, 0, 1'b1);
    // seg_ready toggling
    run_job(2, 1, 0, 0, 0, 1'b1);
    // zero-length job
    run_job(0, 0, 0, 0, 0, 1'b1);
    chk("zero_busy", 64'(busy_seen), 64'd0);
    chk("zero_lat", 64'((done_cyc - start_cyc) inside {[1:2]}), 64'd1);
    // start while busy is ignored
    run_job(3, 0, 0, 0, 5, 1'b1);
    // clock-enable freeze mid-stream
    run_job(3, 0, 0, 8, 0, 1'b1);

    // reset while a word is in flight
    clear_job(4);
    for (int n = 0; n < 4; n++) begin
      logic [CW-1:0] w;
      for (int j = 0; j < NS; j++) w[j*SW +: SW] = SW'(n * 16 + j + 3);
      word_q.push_back(w);
    end
    rdy_mode = 0; emp_mode = 0;
    @(posedge clk); #1; start = 1'b1; word_count = 16'd4;
    @(posedge clk); #1; start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!read_req02 && k < 20);
    chk("mid_req", 64'(read_req02), 64'd1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    word_q.delete(); exp_q.delete();
    ghost = 0;
    repeat (8) begin
      @(negedge clk);
      if (seg_valid || busy) ghost++;
    end
    chk("no_ghost", 64'(ghost), 64'd0);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      wc = $urandom_range(1, 5);
      run_job(wc, $urandom_range(0, 2), $urandom_range(0, 2),
              ($urandom_range(0, 1) == 1) ? $urandom_range(8, 20) : 0,
              ($urandom_range(0, 1) == 1) ? $urandom_range(3, 6) : 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
